// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave register bank: default bus widths,
// transfer-counter width and the slave FSM state encoding.
package apb_pkg;

   localparam int DATA_W     = 8;
   localparam int ADDR_W     = 8;
   localparam int XFER_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10,
      READY  = 2'b11
   } apb_state_e;

endpackage

// File: rtl/apb_regbank_mem.sv
// DEPTH x DATA_W register storage: asynchronous clear, one synchronous write
// port and one combinational read port.
module apb_regbank_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // Next contents: only the addressed entry changes, and only on a write.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = (we && (wr_idx == IDX_W'(i))) ? wr_data : mem_q[i];
      end
   end

   // Storage flops, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave register bank. Tracks the master's setup/access phases, inserts
// WAIT_CYCLES extra wait states, flags out-of-range addresses with pslverr,
// commits writes on the completion edge and counts completed transfers.
module apb_slave_regbank #(
   parameter int DATA_W      = apb_pkg::DATA_W,
   parameter int ADDR_W      = apb_pkg::ADDR_W,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          psel,
   input  logic                          penable,
   input  logic                          pwrite,
   input  logic [ADDR_W-1:0]             paddr,
   input  logic [DATA_W-1:0]             pwdata,
   output logic [DATA_W-1:0]             prdata,
   output logic                          pready,
   output logic                          pslverr,
   output logic                          wr_pulse,
   output logic [apb_pkg::XFER_CNT_W-1:0] xfer_cnt
);

   import apb_pkg::*;

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
   // The SETUP-state cycle is the first access cycle and already serves as the
   // inherent wait, so ACCESS only has WAIT_CYCLES-1 further cycles to count.
   localparam logic [WC_W-1:0] WC_FIRST = (WAIT_CYCLES > 0) ? WC_W'(WAIT_CYCLES - 1) : '0;

   function automatic logic [XFER_CNT_W-1:0] sat_inc(input logic [XFER_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   apb_state_e              state_q, state_d;
   logic [WC_W-1:0]         wait_q, wait_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    write_q, write_d;
   logic [DATA_W-1:0]       prdata_q, prdata_d;
   logic                    pready_q, pready_d;
   logic                    pslverr_q, pslverr_d;
   logic                    wr_pulse_q, wr_pulse_d;
   logic [XFER_CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;

   logic                    complete;
   logic                    commit;
   logic                    in_range;
   logic [DATA_W-1:0]       rd_data;

   assign in_range = ({1'b0, paddr} < DEPTH_A);

   apb_regbank_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we      (commit),
      .wr_idx  (idx_q),
      .wr_data (pwdata),
      .rd_idx  (paddr[IDX_W-1:0]),
      .rd_data (rd_data)
   );

   // Next-state and registered-output logic for the transfer FSM.
   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      idx_d      = idx_q;
      write_d    = write_q;
      prdata_d   = prdata_q;
      pready_d   = pready_q;
      pslverr_d  = pslverr_q;
      wr_pulse_d = 1'b0;
      xfer_cnt_d = xfer_cnt_q;
      complete   = 1'b0;
      commit     = 1'b0;

      case (state_q)
         IDLE: begin
            // A lingering penable from the previous transfer is not a setup.
            if (psel && !penable) state_d = SETUP;
         end
         SETUP: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               if (WAIT_CYCLES == 0) begin
                  complete = 1'b1;
               end else begin
                  state_d = ACCESS;
                  wait_d  = WC_FIRST;
               end
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
               wait_d  = '0;
            end else if (penable) begin
               if (wait_q == '0) complete = 1'b1;
               else              wait_d   = wait_q - 1'b1;
            end
         end
         READY: begin
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            // Losing psel here abandons the transfer: no commit, no count.
            if (psel) begin
               xfer_cnt_d = sat_inc(xfer_cnt_q);
               if (write_q && !pslverr_q) begin
                  commit     = 1'b1;
                  wr_pulse_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (complete) begin
         state_d   = READY;
         pready_d  = 1'b1;
         wait_d    = '0;
         idx_d     = paddr[IDX_W-1:0];
         write_d   = pwrite;
         pslverr_d = !in_range;
         if (!pwrite) prdata_d = in_range ? rd_data : '0;
      end
   end

   // FSM state and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_q     <= '0;
         idx_q      <= '0;
         write_q    <= 1'b0;
         prdata_q   <= '0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
         wr_pulse_q <= 1'b0;
         xfer_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         idx_q      <= idx_d;
         write_q    <= write_d;
         prdata_q   <= prdata_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
         wr_pulse_q <= wr_pulse_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign prdata   = prdata_q;
   assign pready   = pready_q;
   assign pslverr  = pslverr_q;
   assign wr_pulse = wr_pulse_q;
   assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: three instances (WAIT_CYCLES 0, 2, 3) on
// separate buses, a transaction-level model of expected outputs, a per-cycle
// compare process and literal spot checks.
module tb_apb_slave_regbank;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       psel     [3];
   logic       penable  [3];
   logic       pwrite   [3];
   logic [7:0] paddr    [3];
   logic [7:0] pwdata   [3];
   logic [7:0] prdata   [3];
   logic       pready   [3];
   logic       pslverr  [3];
   logic       wr_pulse [3];
   logic [15:0] xfer_cnt [3];

   int errors = 0;
   int checks = 0;

   // model state
   logic [7:0]  mem_m [3][16];
   logic [7:0]  exp_prdata  [3];
   logic        exp_pready  [3];
   logic        exp_pslverr [3];
   logic        exp_wr      [3];
   logic [15:0] exp_cnt     [3];
   bit          cnt_pend    [3];
   bit          wr_pend     [3];
   int          mem_pend_a  [3];
   logic [7:0]  mem_pend_d  [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_slave_regbank #(
         .DATA_W      (8),
         .ADDR_W      (8),
         .DEPTH       (16),
         .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .psel     (psel[g]),
         .penable  (penable[g]),
         .pwrite   (pwrite[g]),
         .paddr    (paddr[g]),
         .pwdata   (pwdata[g]),
         .prdata   (prdata[g]),
         .pready   (pready[g]),
         .pslverr  (pslverr[g]),
         .wr_pulse (wr_pulse[g]),
         .xfer_cnt (xfer_cnt[g])
      );
   end

   function automatic int wc_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
   endfunction

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s[%0d]: actual=%0h required=%0h", name, inst, act, req);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 3; i++) begin
         for (int a = 0; a < 16; a++) mem_m[i][a] = 8'h00;
         exp_prdata[i]  = 8'h00;
         exp_pready[i]  = 1'b0;
         exp_pslverr[i] = 1'b0;
         exp_wr[i]      = 1'b0;
         exp_cnt[i]     = 16'h0;
         cnt_pend[i]    = 1'b0;
         wr_pend[i]     = 1'b0;
      end
   endtask

   // Advance one cycle; effects of the previous completion edge become visible.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         exp_wr[i]      = wr_pend[i];
         if (wr_pend[i]) mem_m[i][mem_pend_a[i]] = mem_pend_d[i];
         if (cnt_pend[i] && exp_cnt[i] != 16'hFFFF) exp_cnt[i] = exp_cnt[i] + 16'd1;
         wr_pend[i]     = 1'b0;
         cnt_pend[i]    = 1'b0;
         exp_pready[i]  = 1'b0;
         exp_pslverr[i] = 1'b0;
      end
   endtask

   task automatic idle();
      tick();
      for (int i = 0; i < 3; i++) begin
         psel[i]    = 1'b0;
         penable[i] = 1'b0;
      end
   endtask

   // Master holds penable high one cycle past pready.
   task automatic linger(input int i);
      tick();
      psel[i]    = 1'b1;
      penable[i] = 1'b1;
      pwrite[i]  = 1'b0;
      paddr[i]   = 8'hEE;
   endtask

   // One APB transfer; returns during the pready cycle unless dropped/reset.
   task automatic xfer(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input int drop_at, input int rst_at);
      int n;
      n = 2 + wc_of(i);
      tick();
      psel[i]    = 1'b1;
      penable[i] = 1'b0;
      pwrite[i]  = wr;
      paddr[i]   = ~a;
      pwdata[i]  = d;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (k == drop_at) begin
            psel[i]    = 1'b0;
            penable[i] = 1'b0;
            return;
         end
         penable[i] = 1'b1;
         paddr[i]   = a;
         if (k == rst_at) begin
            rst = 1'b1;
            reset_model();
            return;
         end
         if (k == n) begin
            exp_pready[i]  = 1'b1;
            exp_pslverr[i] = (a >= 8'd16);
            if (!wr) exp_prdata[i] = (a < 8'd16) ? mem_m[i][a[3:0]] : 8'h00;
            cnt_pend[i] = 1'b1;
            if (wr && a < 8'd16) begin
               wr_pend[i]    = 1'b1;
               mem_pend_a[i] = int'(a[3:0]);
               mem_pend_d[i] = d;
            end
         end
      end
   endtask

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk("pready",   i, 32'(pready[i]),   32'(exp_pready[i]));
         chk("pslverr",  i, 32'(pslverr[i]),  32'(exp_pslverr[i]));
         chk("prdata",   i, 32'(prdata[i]),   32'(exp_prdata[i]));
         chk("wr_pulse", i, 32'(wr_pulse[i]), 32'(exp_wr[i]));
         chk("xfer_cnt", i, 32'(xfer_cnt[i]), 32'(exp_cnt[i]));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
         paddr[i] = 8'h00; pwdata[i] = 8'h00;
      end
      reset_model();
      tick();
      tick();
      rst = 1'b0;
      idle();
      chk("rst_pready",  0, 32'(pready[0]),   32'h0);
      chk("rst_prdata",  0, 32'(prdata[0]),   32'h0);
      chk("rst_cnt",     0, 32'(xfer_cnt[0]), 32'h0);

      // write 0x5A @0x03, W=0, then read it back
      xfer(0, 1'b1, 8'h03, 8'h5A, 0, 0);
      chk("w5a_pready", 0, 32'(pready[0]), 32'h1);
      idle();
      chk("w5a_wr_pulse", 0, 32'(wr_pulse[0]), 32'h1);
      chk("w5a_cnt",      0, 32'(xfer_cnt[0]), 32'h1);
      idle();
      chk("w5a_wr_pulse_off", 0, 32'(wr_pulse[0]), 32'h0);
      xfer(0, 1'b0, 8'h03, 8'h00, 0, 0);
      chk("r03_prdata",  0, 32'(prdata[0]),  32'h5A);
      chk("r03_pslverr", 0, 32'(pslverr[0]), 32'h0);
      idle();

      // W=3: write 0xC3 @0x0F then read
      xfer(2, 1'b1, 8'h0F, 8'hC3, 0, 0);
      idle();
      xfer(2, 1'b0, 8'h0F, 8'h00, 0, 0);
      chk("r0f_prdata", 2, 32'(prdata[2]), 32'hC3);
      idle();

      // out-of-range write and read
      xfer(0, 1'b1, 8'h10, 8'h77, 0, 0);
      chk("w10_pslverr", 0, 32'(pslverr[0]), 32'h1);
      chk("w10_prdata_held", 0, 32'(prdata[0]), 32'h5A);
      idle();
      chk("w10_wr_pulse", 0, 32'(wr_pulse[0]), 32'h0);
      chk("w10_cnt",      0, 32'(xfer_cnt[0]), 32'h3);
      xfer(0, 1'b0, 8'h10, 8'h00, 0, 0);
      chk("r10_prdata",  0, 32'(prdata[0]),  32'h00);
      chk("r10_pslverr", 0, 32'(pslverr[0]), 32'h1);
      idle();

      // back-to-back with lingering penable
      xfer(0, 1'b1, 8'h01, 8'h11, 0, 0);
      linger(0);
      xfer(0, 1'b0, 8'h01, 8'h00, 0, 0);
      chk("b2b_prdata", 0, 32'(prdata[0]),   32'h11);
      chk("b2b_cnt",    0, 32'(xfer_cnt[0]), 32'h5);
      idle();

      // psel dropped in ACCESS, W=2
      xfer(1, 1'b1, 8'h02, 8'hAA, 2, 0);
      idle();
      idle();
      chk("drop_cnt", 1, 32'(xfer_cnt[1]), 32'h0);
      xfer(1, 1'b0, 8'h02, 8'h00, 0, 0);
      chk("drop_prdata", 1, 32'(prdata[1]), 32'h00);
      idle();

      // reset in the middle of ACCESS, W=2
      xfer(1, 1'b1, 8'h05, 8'h99, 0, 0);
      idle();
      xfer(1, 1'b1, 8'h06, 8'h42, 0, 3);
      #1;
      chk("mid_rst_pready", 1, 32'(pready[1]),   32'h0);
      chk("mid_rst_cnt1",   1, 32'(xfer_cnt[1]), 32'h0);
      chk("mid_rst_cnt0",   0, 32'(xfer_cnt[0]), 32'h0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         psel[i] = 1'b0; penable[i] = 1'b0;
      end
      idle();
      chk("post_rst_wr_pulse", 1, 32'(wr_pulse[1]), 32'h0);
      xfer(1, 1'b0, 8'h05, 8'h00, 0, 0);
      chk("post_rst_r05", 1, 32'(prdata[1]), 32'h00);
      idle();
      xfer(1, 1'b0, 8'h06, 8'h00, 0, 0);
      chk("post_rst_r06", 1, 32'(prdata[1]), 32'h00);
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB slave register bank that sits directly downstream of the team's APB master and consumes its psel/penable/pwrite/paddr/pwdata bus.
- Returns pready/prdata to the master and holds DEPTH x DATA_W registers.
- Inserts a configurable number of wait states per transfer and flags out-of-range accesses.
- Provides the programmable-peripheral endpoint used in master+slave system sims.

Parameters:
- DATA_W, 8, data width of pwdata, prdata and each register.
- ADDR_W, 8, width of paddr.
- DEPTH, 16, number of registers. Must be at most 2**ADDR_W.
- WAIT_CYCLES, 0, extra wait states on top of the one inherent wait cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- psel  input  1  slave select.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  transfer address.
- pwdata  input  DATA_W  write data.
- prdata  output  DATA_W  read data, registered.
- pready  output  1  transfer-complete, registered.
- pslverr  output  1  error, valid only while pready=1. The master may leave it unconnected.
- wr_pulse  output  1  one-cycle pulse on each committed register write.
- xfer_cnt  output  16  count of completed transfers (reads and writes, including errored ones); saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous, rst=1):
  - prdata=0, pready=0, pslverr=0, wr_pulse=0, xfer_cnt=0.
  - All registers are cleared to 0. The FSM goes to IDLE and the wait counter to 0.
  - Reset mid-transfer aborts it with no write commit. The master must restart.
- FSM states and transitions:
  - IDLE -> SETUP when psel=1 and penable=0.
  - psel=1 with penable=1 while in IDLE is ignored. This covers a master that holds penable into its next setup cycle; the slave waits until it sees penable=0.
  - SETUP (the master's setup cycle has been seen): at the next edge go to ACCESS and load wait_cnt=WAIT_CYCLES.
  - ACCESS: while penable=1 and wait_cnt!=0, decrement wait_cnt.
  - ACCESS: at the edge where wait_cnt==0, sample paddr and pwrite, set pready<=1 and go to READY.
  - ACCESS, read case: prdata<=mem[paddr] if paddr<DEPTH, else prdata<=0 and pslverr<=1.
  - ACCESS, write case: prdata is held. pslverr<=1 if paddr>=DEPTH.
  - READY (pready=1 this cycle): at the edge, if write and no error, mem[paddr]<=pwdata sampled at this edge, and wr_pulse<=1 for one cycle.
  - READY: at the same edge, pready<=0, pslverr<=0, xfer_cnt increments (saturating), and the FSM returns to IDLE.
- Latency: if the setup cycle is S and the first access cycle is A1, pready is high in access cycle A(2+WAIT_CYCLES). The minimum is 1 wait cycle; the slave never completes in A1.
- Address/data stability: paddr is sampled only in the access phase, never in setup, because the master drives paddr with penable. pwdata is sampled at the completion edge.
- Protocol violations:
  - psel dropping to 0 in SETUP, ACCESS or READY abandons the transfer: return to IDLE, pready=0, no commit, no count.
  - penable=0 during ACCESS freezes wait_cnt.
- prdata holds its last read value between transfers and is not cleared after a write.
- Back-to-back transfers: the earliest new setup accepted is the cycle after pready (IDLE detection).
- The saturating xfer_cnt does not wrap.

Decomposition:
- Package apb_pkg holds:
  - FSM state encodings: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, READY=2'b11.
  - Default widths DATA_W and ADDR_W.
  - XFER_CNT_W=16.
- One sub-module, apb_regbank_mem: DEPTH x DATA_W storage with asynchronous clear on rst, synchronous write enable, and combinational read by index.

Test Plan:
- Reset mid-ACCESS with WAIT_CYCLES=2: assert rst -> pready=0 immediately, no write committed, xfer_cnt=0, and a later read of any address returns 0x00.
- Write 0x5A to addr 0x03, WAIT_CYCLES=0 -> pready high exactly in A2, wr_pulse=1 for one cycle after, xfer_cnt=1. A following read of 0x03 returns prdata=0x5A with pslverr=0.
- WAIT_CYCLES=3, read addr 0x0F after writing 0xC3 -> pready low for A1..A4, high in A5 with prdata=0xC3.
- Write 0x77 to addr 0x10 (DEPTH=16) -> pslverr=1 with pready, no wr_pulse, xfer_cnt increments. A read of 0x10 returns prdata=0x00 with pslverr=1.
- Master back-to-back write 0x11@0x01 then read @0x01 with penable held high for one cycle after pready -> slave ignores the lingering penable, the second transfer starts on its setup cycle, and the read returns 0x11.
- Drop psel in ACCESS during a write of 0xAA@0x02 -> no commit (a read of 0x02 returns 0x00), xfer_cnt unchanged, FSM back in IDLE.
